// File: rtl/fp128_unpack_pipe_pkg.sv
// Widths, constants and shared types for the binary128 unpacker datapath.
// Also provides the operand classifier used by the first pipeline stage.
package fp128Pkg;

   localparam int FMSB = 111;
   localparam int EMSB = 14;

   localparam logic [EMSB:0]   FP128_EXP_ONES = 15'h7FFF;
   localparam logic [EMSB+1:0] FP128_BIAS     = 16'h3FFF;

   typedef struct packed {
      logic            sign;
      logic [EMSB+1:0] exp;
      logic [FMSB+1:0] man;
      logic            zero;
      logic            inf;
      logic            qnan;
      logic            snan;
      logic            sub;
   } fp128_unpacked_t;

   typedef struct packed {
      logic zero;
      logic inf;
      logic qnan;
      logic snan;
      logic sub;
   } fp128_class_t;

   // At most one flag is ever set; all clear means a normal number.
   function automatic fp128_class_t fp128_classify(
      input logic [EMSB:0] e,
      input logic [FMSB:0] f
   );
      fp128_class_t c;
      logic         e_zero;
      logic         e_ones;
      logic         f_zero;
      e_zero = (e == 15'h0000);
      e_ones = (e == FP128_EXP_ONES);
      f_zero = (f == 112'd0);
      c.zero = e_zero & f_zero;
      c.sub  = e_zero & ~f_zero;
      c.inf  = e_ones & f_zero;
      c.qnan = e_ones & f[FMSB];
      c.snan = e_ones & ~f[FMSB] & ~f_zero;
      return c;
   endfunction

endpackage

// File: rtl/fp128_unpack_pipe_lzc113.sv
// Combinational 113-bit leading-zero counter; reports 113 for an all-zero input.
module fp128_lzc113
   import fp128Pkg::*;
(
   input  logic [FMSB+1:0] i_data,
   output logic [6:0]      o_lz
);

   // Ascending scan: each higher set bit overrides the count from lower ones.
   always_comb begin
      o_lz = 7'd113;
      for (int i = 0; i <= FMSB + 1; i++) begin
         o_lz = i_data[i] ? 7'(FMSB + 1 - i) : o_lz;
      end
   end

endmodule

// File: rtl/fp128_unpack_pipe.sv
// Three-stage binary128 unpacker (classify / count / form) with valid-ready flow.
// Define FP128_UNPACK_PRENORM_EN to pre-normalize subnormal mantissas.
module fp128_unpack_pipe
   import fp128Pkg::*;
#(
   parameter int TAGW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ce,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    in_data,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_sign,
   output logic [EMSB+1:0] out_exp,
   output logic [FMSB+1:0] out_man,
   output logic            out_zero,
   output logic            out_inf,
   output logic            out_qnan,
   output logic            out_snan,
   output logic            out_sub,
   output logic [TAGW-1:0] out_tag
);

   logic            r_s1_v;
   logic            r_s1_sign;
   logic [EMSB:0]   r_s1_exp;
   logic [FMSB:0]   r_s1_frac;
   fp128_class_t    r_s1_cls;
   logic [TAGW-1:0] r_s1_tag;

   logic            r_s2_v;
   logic            r_s2_sign;
   logic [EMSB:0]   r_s2_exp;
   logic [FMSB:0]   r_s2_frac;
   fp128_class_t    r_s2_cls;
   logic [TAGW-1:0] r_s2_tag;

   logic            r_s3_v;
   fp128_unpacked_t r_s3_res;
   logic [TAGW-1:0] r_s3_tag;

   logic            w_s1_free;
   logic            w_s2_free;
   logic            w_s3_free;
   fp128_unpacked_t w_s3_res;

   // A stage may load when it is empty or its content moves on this cycle.
   assign w_s3_free = ~r_s3_v | out_ready;
   assign w_s2_free = ~r_s2_v | w_s3_free;
   assign w_s1_free = ~r_s1_v | w_s2_free;
   assign in_ready  = w_s1_free;

`ifdef FP128_UNPACK_PRENORM_EN
   logic [6:0] w_lz;
   logic [6:0] r_s2_lz;

   fp128_lzc113 u_lzc (
      .i_data ({|r_s1_exp, r_s1_frac}),
      .o_lz   (w_lz)
   );
`endif

   // S1: capture the operand and classify it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_exp  <= '0;
         r_s1_frac <= '0;
         r_s1_cls  <= '0;
         r_s1_tag  <= '0;
      end else if (ce && w_s1_free) begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_s1_sign <= in_data[127];
            r_s1_exp  <= in_data[126:112];
            r_s1_frac <= in_data[111:0];
            r_s1_cls  <= fp128_classify(in_data[126:112], in_data[111:0]);
            r_s1_tag  <= in_tag;
         end
      end
   end

   // S2: carry the operand forward, plus its leading-zero count when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v    <= 1'b0;
         r_s2_sign <= 1'b0;
         r_s2_exp  <= '0;
         r_s2_frac <= '0;
         r_s2_cls  <= '0;
         r_s2_tag  <= '0;
`ifdef FP128_UNPACK_PRENORM_EN
         r_s2_lz   <= 7'd0;
`endif
      end else if (ce && w_s2_free) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_frac <= r_s1_frac;
            r_s2_cls  <= r_s1_cls;
            r_s2_tag  <= r_s1_tag;
`ifdef FP128_UNPACK_PRENORM_EN
            r_s2_lz   <= w_lz;
`endif
         end
      end
   end

   // S3 datapath: build the expanded form; NaN payloads pass through untouched.
   always_comb begin
      w_s3_res      = '0;
      w_s3_res.sign = r_s2_sign;
      w_s3_res.zero = r_s2_cls.zero;
      w_s3_res.inf  = r_s2_cls.inf;
      w_s3_res.qnan = r_s2_cls.qnan;
      w_s3_res.snan = r_s2_cls.snan;
      w_s3_res.sub  = r_s2_cls.sub;
      if (r_s2_cls.zero) begin
         w_s3_res.exp = 16'd0;
         w_s3_res.man = 113'd0;
      end else if (r_s2_cls.sub) begin
`ifdef FP128_UNPACK_PRENORM_EN
         // Hidden bit is 0, so lz >= 1 and the shift lands the MSB on bit 112.
         w_s3_res.exp = 16'd1 - {9'd0, r_s2_lz};
         w_s3_res.man = {1'b0, r_s2_frac} << r_s2_lz;
`else
         w_s3_res.exp = 16'd1;
         w_s3_res.man = {1'b0, r_s2_frac};
`endif
      end else begin
         w_s3_res.exp = {1'b0, r_s2_exp};
         w_s3_res.man = {1'b1, r_s2_frac};
      end
   end

   // S3: output register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3_v   <= 1'b0;
         r_s3_res <= '0;
         r_s3_tag <= '0;
      end else if (ce && w_s3_free) begin
         r_s3_v <= r_s2_v;
         if (r_s2_v) begin
            r_s3_res <= w_s3_res;
            r_s3_tag <= r_s2_tag;
         end
      end
   end

   assign out_valid = r_s3_v;
   assign out_sign  = r_s3_res.sign;
   assign out_exp   = r_s3_res.exp;
   assign out_man   = r_s3_res.man;
   assign out_zero  = r_s3_res.zero;
   assign out_inf   = r_s3_res.inf;
   assign out_qnan  = r_s3_res.qnan;
   assign out_snan  = r_s3_res.snan;
   assign out_sub   = r_s3_res.sub;
   assign out_tag   = r_s3_tag;

endmodule

// File: tb/tb_fp128_unpack_pipe.sv
// Scoreboard bench for fp128_unpack_pipe: expectations are queued on accept
// and compared on emit; follows FP128_UNPACK_PRENORM_EN like the design.
module tb_fp128_unpack_pipe;
   import fp128Pkg::*;

   localparam int TAGW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ce = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [127:0]    in_data = '0;
   logic [TAGW-1:0] in_tag = '0;
   logic            in_ready, out_valid, out_sign;
   logic            out_zero, out_inf, out_qnan, out_snan, out_sub;
   logic [15:0]     out_exp;
   logic [112:0]    out_man;
   logic [TAGW-1:0] out_tag;

   int checks = 0;
   int errors = 0;

   fp128_unpacked_t exp_q[$];
   logic [TAGW-1:0] tag_q[$];

   always #5 clk = ~clk;

   fp128_unpack_pipe #(.TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
      .out_exp(out_exp), .out_man(out_man), .out_zero(out_zero), .out_inf(out_inf),
      .out_qnan(out_qnan), .out_snan(out_snan), .out_sub(out_sub), .out_tag(out_tag)
   );

   function automatic fp128_unpacked_t model(input logic [127:0] d);
      fp128_unpacked_t r;
      logic [14:0]     e;
      logic [111:0]    f;
      int              lz;
      logic            found;
      e = d[126:112];
      f = d[111:0];
      r = '0;
      r.sign = d[127];
      if (e == 15'd0 && f == 112'd0) begin
         r.zero = 1'b1;
      end else if (e == 15'd0) begin
         r.sub = 1'b1;
`ifdef FP128_UNPACK_PRENORM_EN
         found = 1'b0;
         lz = 0;
         for (int i = 111; i >= 0; i--) begin
            if (!found && f[i]) begin
               found = 1'b1;
               lz = 112 - i;
            end
         end
         r.man = {1'b0, f} << lz;
         r.exp = 16'(1 - lz);
`else
         found = 1'b0;
         lz = 0;
         r.exp = 16'd1;
         r.man = {1'b0, f};
`endif
      end else begin
         r.exp = {1'b0, e};
         r.man = {1'b1, f};
         if (e == 15'h7FFF) begin
            r.inf  = (f == 112'd0);
            r.qnan = f[111];
            r.snan = !f[111] && (f != 112'd0);
         end
      end
      return r;
   endfunction

   function automatic fp128_unpacked_t observed();
      return {out_sign, out_exp, out_man, out_zero, out_inf, out_qnan, out_snan, out_sub};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ce = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if ({observed(), out_tag} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h tag %h expected all zero", observed(), out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_classes();
      logic [127:0]    vec [10];
      fp128_unpacked_t e, got;
      logic [TAGW-1:0] et;
      bit              accepted, seen;
      int              lat;
      vec[0] = {16'h3FFF, 112'd0};
      vec[1] = 128'd1;
      vec[2] = {16'h7FFF, 112'd0};
      vec[3] = {16'h7FFF, 1'b1, 111'd0};
      vec[4] = {16'h7FFF, 112'd1};
      vec[5] = {16'h8000, 112'd0};
      vec[6] = {16'hC000, 56'h00ABCDEF012345, 56'h0F0F0F0F0F0F0F};
      vec[7] = {16'h0000, 2'b01, 110'd5};
      vec[8] = {16'hFFFF, 1'b1, 111'd12345};
      vec[9] = {16'h7FFE, {112{1'b1}}};
      out_ready = 1'b1;
      ce = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data = vec[i];
         in_tag = 8'(100 + i);
         accepted = 1'b0;
         for (int c = 0; c < 10 && !accepted; c++) begin
            @(negedge clk);
            if (in_valid && in_ready && ce) begin
               accepted = 1'b1;
               exp_q.push_back(model(vec[i]));
               tag_q.push_back(in_tag);
            end
            tick();
         end
         in_valid = 1'b0;
         checks++;
         if (!accepted) begin errors++; $display("FAIL class_accept[%0d]: got no accept expected accept", i); end
         lat = 1;
         seen = 1'b0;
         for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin tick(); lat++; end
         end
         checks++;
         if (!seen || lat != 3) begin
            errors++;
            $display("FAIL class_latency[%0d]: got %0d (seen %b) expected 3", i, lat, seen);
         end
         if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            et = tag_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin errors++; $display("FAIL class_result[%0d]: got %h expected %h", i, got, e); end
            checks++;
            if (out_tag !== et) begin errors++; $display("FAIL class_tag[%0d]: got %h expected %h", i, out_tag, et); end
            if (i == 0) begin
               checks++;
               if (out_exp !== 16'h3FFF || out_man !== {1'b1, 112'd0})
                  begin errors++; $display("FAIL one_literal: got exp %h man %h expected 3fff and 1<<112", out_exp, out_man); end
            end
            if (i == 1) begin
               checks++;
`ifdef FP128_UNPACK_PRENORM_EN
               if (out_exp !== 16'hFF91 || out_man !== {1'b1, 112'd0} || out_sub !== 1'b1)
`else
               if (out_exp !== 16'h0001 || out_man !== 113'd1 || out_sub !== 1'b1)
`endif
                  begin errors++; $display("FAIL minsub_literal: got exp %h man %h sub %b", out_exp, out_man, out_sub); end
            end
         end else begin
            exp_q.delete();
            tag_q.delete();
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [127:0]    vec [10];
      fp128_unpacked_t e, got;
      logic [TAGW-1:0] et;
      int              sent, rcvd;
      for (int i = 0; i < 10; i++) begin
         vec[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (i % 3 == 0) vec[i][126:112] = 15'd0;
      end
      sent = 0;
      rcvd = 0;
      ce = 1'b1;
      for (int c = 0; c < 80 && rcvd < 10; c++) begin
         in_valid = (sent < 10);
         in_data = vec[sent % 10];
         in_tag = 8'(sent);
         out_ready = !(c >= 4 && c <= 9);
         @(negedge clk);
         if (c >= 4 && c <= 9) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[c%0d]: got %b expected 0", c, in_ready); end
         end
         if (out_valid && out_ready && ce) begin
            got = observed();
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: got tag %h expected no output", out_tag);
            end else begin
               e = exp_q.pop_front();
               et = tag_q.pop_front();
               if (got !== e || out_tag !== et || out_tag !== 8'(rcvd)) begin
                  errors++;
                  $display("FAIL bp_result[%0d]: got %h tag %h expected %h tag %h", rcvd, got, out_tag, e, et);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready && ce) begin
            exp_q.push_back(model(in_data));
            tag_q.push_back(in_tag);
            sent++;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (rcvd != 10 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d received %0d pending expected 10 and 0", rcvd, exp_q.size());
      end
      exp_q.delete();
      tag_q.delete();
   endtask

   task automatic test_ce_hold();
      fp128_unpacked_t e, got;
      logic [TAGW-1:0] et;
      logic [154:0]    snap, now;
      int              sent, rcvd;
      sent = 0;
      rcvd = 0;
      snap = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && rcvd < 8; c++) begin
         in_valid = (sent < 8);
         in_data = {1'b0, 15'(16'h3F00 + sent), 56'(sent * 977), 56'hA5};
         in_tag = 8'(20 + sent);
         ce = !(c == 4 || c == 5);
         @(negedge clk);
         now = {out_valid, in_ready, out_tag, 10'd0, observed()};
         if (c == 4) begin
            snap = now;
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL ce_full: got out_valid %b expected 1", out_valid); end
         end
         if (c == 5 || c == 6) begin
            checks++;
            if (now !== snap) begin errors++; $display("FAIL ce_hold[c%0d]: got %h expected %h", c, now, snap); end
         end
         if (out_valid && out_ready && ce) begin
            got = observed();
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ce_extra: got tag %h expected no output", out_tag);
            end else begin
               e = exp_q.pop_front();
               et = tag_q.pop_front();
               if (got !== e || out_tag !== et) begin
                  errors++;
                  $display("FAIL ce_result[%0d]: got %h tag %h expected %h tag %h", rcvd, got, out_tag, e, et);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready && ce) begin
            exp_q.push_back(model(in_data));
            tag_q.push_back(in_tag);
            sent++;
         end
         tick();
      end
      in_valid = 1'b0;
      ce = 1'b1;
      checks++;
      if (rcvd != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ce_count: got %0d received %0d pending expected 8 and 0", rcvd, exp_q.size());
      end
      exp_q.delete();
      tag_q.delete();
   endtask

   task automatic test_async_reset();
      fp128_unpacked_t e, got;
      int              stale;
      bit              seen;
      ce = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = {16'h4000, 112'(i + 7)};
         in_tag = 8'(50 + i);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_prefill: got out_valid %b expected 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
      end
      checks++;
      if ({observed(), out_tag} !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", observed()); end
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
         tick();
      end
      checks++;
      if (stale != 0) begin errors++; $display("FAIL rst_stale: got %0d outputs expected 0", stale); end
      in_valid = 1'b1;
      in_data = {16'hBFFE, 112'd3};
      in_tag = 8'hEE;
      e = model(in_data);
      tick();
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else tick();
      end
      got = observed();
      checks++;
      if (!seen || got !== e || out_tag !== 8'hEE) begin
         errors++;
         $display("FAIL rst_recover: got %h tag %h seen %b expected %h tag ee", got, out_tag, seen, e);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_classes();
      test_backpressure();
      test_ce_hold();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
